// File: rtl/jkff_drive_pkg.sv
// Shared types and J/K encodings for the JK flip-flop command stage.
package jkff_drive_pkg;

  typedef enum logic [1:0] {INIT, IDLE, DRIVE, HOLD} state_t;

  localparam int REQ_HOLD_W = 4;

  typedef struct packed {
    logic                  target;
    logic [REQ_HOLD_W-1:0] hold;
  } req_t;

  // {j, k} pairs
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

// File: rtl/jkff_drive_fifo.sv
// Request buffer: synchronous FIFO whose pointers carry an extra wrap bit so
// full and empty can be told apart without a separate count.
module jkff_drive_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/jkff_drive_seq.sv
// Command stage for the JK flip-flop: buffers (target, hold) requests, emits
// the J/K pair reaching each target, and tracks the JKFF output in q_pred.
module jkff_drive_seq
  import jkff_drive_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = REQ_HOLD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic              in_target,
  input  logic [HOLD_W-1:0] in_hold,
  input  logic              use_toggle,
  output logic              j,
  output logic              k,
  output logic              q_pred,
  output logic              busy
);

  state_t            state;
  state_t            state_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [HOLD_W:0]   head;
  logic              cur_target;
  logic [HOLD_W-1:0] cur_hold;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        jk;

  assign in_rdy = !fifo_full;
  assign busy   = (state != IDLE);
  assign j      = jk[1];
  assign k      = jk[0];

  jkff_drive_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(HOLD_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_val && in_rdy),
    .push_data ({in_target, in_hold}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    jk         = JK_HOLD;
    unique case (state)
      INIT: begin
        jk         = JK_RST;
        state_next = IDLE;
      end
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (cur_target != q_pred)
          jk = use_toggle ? JK_TOG : (cur_target ? JK_SET : JK_RST);
        if (cur_hold != '0) begin
          state_next = HOLD;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        // Chain straight into the next request on the last hold cycle.
        if (hold_cnt == HOLD_W'(1)) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = DRIVE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      q_pred     <= 1'b0;
      hold_cnt   <= '0;
      cur_target <= 1'b0;
      cur_hold   <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        cur_target <= head[HOLD_W];
        cur_hold   <= head[HOLD_W-1:0];
      end
      if (state == DRIVE)
        hold_cnt <= cur_hold;
      else if (state == HOLD)
        hold_cnt <= hold_cnt - 1'b1;
      case (jk)
        JK_RST:  q_pred <= 1'b0;
        JK_SET:  q_pred <= 1'b1;
        JK_TOG:  q_pred <= ~q_pred;
        default: q_pred <= q_pred;
      endcase
    end
  end

endmodule

// File: tb/tb_jkff_drive_seq.sv
// Scoreboard bench: stimulus schedules each accepted request's DRIVE cycle,
// the monitor checks j/k, busy, q_pred and in_rdy against that schedule.
module tb_jkff_drive_seq;
  import jkff_drive_pkg::*;

  localparam int DEPTH  = 4;
  localparam int HOLD_W = REQ_HOLD_W;

  typedef struct {
    req_t req;
    int   drive;
  } sched_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_val = 1'b0;
  logic              in_target = 1'b0;
  logic              use_toggle = 1'b0;
  logic [HOLD_W-1:0] in_hold = '0;
  logic              in_rdy;
  logic              j;
  logic              k;
  logic              q_pred;
  logic              busy;

  jkff_drive_seq #(
    .DEPTH (DEPTH),
    .HOLD_W(HOLD_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_target (in_target),
    .in_hold   (in_hold),
    .use_toggle(use_toggle),
    .j         (j),
    .k         (k),
    .q_pred    (q_pred),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int       cyc = 0;
  sched_t   sb_q[$];
  int       pending_q[$];
  int       checks = 0;
  int       failures = 0;
  int       init_cyc = 1 << 30;
  int       busy_until = -1;
  int       last_end = 0;
  int       accepted = 0;
  logic     q_exp = 1'b0;
  logic     started = 1'b0;
  logic     jkff_q;
  sched_t   mon_s;
  logic [1:0] mon_jk;
  logic     mon_drive;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent JKFF driven by the DUT's j/k; it has no reset of its own.
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   jkff_q <= 1'b0;
      2'b10:   jkff_q <= 1'b1;
      2'b11:   jkff_q <= ~jkff_q;
      default: jkff_q <= jkff_q;
    endcase
  end

  task automatic check_output(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic t, input logic [HOLD_W-1:0] h,
                                input logic tog);
    int d;
    sched_t s;
    @(negedge clk);
    while (pending_q.size() > 0 && pending_q[0] <= cyc) void'(pending_q.pop_front());
    check_output("in_rdy", {1'b0, in_rdy}, {1'b0, pending_q.size() < DEPTH});
    in_val     = v;
    in_target  = t;
    in_hold    = h;
    use_toggle = tog;
    if (v && in_rdy) begin
      d = (last_end + 1 > cyc + 2) ? last_end + 1 : cyc + 2;
      last_end = d + int'(h);
      s.req.target = t;
      s.req.hold   = h;
      s.drive      = d;
      sb_q.push_back(s);
      pending_q.push_back(d);
      accepted++;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset  = 1'b1;
    in_val = 1'b0;
    sb_q.delete();
    pending_q.delete();
    q_exp   = 1'b0;
    started = 1'b1;
    repeat (n) @(negedge clk);
    init_cyc   = cyc;
    busy_until = cyc;
    last_end   = cyc;
    reset      = 1'b0;
  endtask

  task automatic drain(input int budget, input logic tog);
    int n = 0;
    while ((sb_q.size() > 0 || cyc <= last_end + 1) && n < budget) begin
      apply_stimulus(1'b0, 1'b0, '0, tog);
      n++;
    end
    checks++;
    if (sb_q.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain cyc=%0d actual=%0d_pending required=0", cyc, sb_q.size());
    end
  endtask

  // Monitor: samples mid-cycle, after the stimulus has settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        check_output("reset_jk", {j, k}, 2'b01);
        check_output("reset_busy", {1'b0, busy}, 2'b01);
        check_output("reset_q", {1'b0, q_pred}, 2'b00);
        check_output("reset_rdy", {1'b0, in_rdy}, 2'b01);
      end else if (started) begin
        mon_jk    = 2'b00;
        mon_drive = 1'b0;
        if (cyc == init_cyc) begin
          mon_jk = 2'b01;
        end else if (sb_q.size() > 0 && sb_q[0].drive <= cyc) begin
          mon_s     = sb_q.pop_front();
          mon_drive = 1'b1;
          checks++;
          if (mon_s.drive != cyc) begin
            failures++;
            $display("[TB] FAIL sched cyc=%0d actual=%0d required=%0d", cyc, cyc, mon_s.drive);
          end
          if (mon_s.req.target != q_exp)
            mon_jk = use_toggle ? 2'b11 : {mon_s.req.target, ~mon_s.req.target};
          busy_until = cyc + int'(mon_s.req.hold);
        end
        check_output("jk", {j, k}, mon_jk);
        check_output("busy", {1'b0, busy}, {1'b0, cyc <= busy_until});
        check_output("q_pred", {1'b0, q_pred}, {1'b0, q_exp});
        if (cyc > init_cyc) check_output("jkff_q", {1'b0, jkff_q}, {1'b0, q_pred});
        if (mon_drive) q_exp = mon_s.req.target;
      end
    end
  end

  initial begin
    int n;
    int acc0;
    do_reset(2);
    repeat (3) apply_stimulus(1'b0, 1'b0, '0, 1'b0);

    apply_stimulus(1'b1, 1'b1, HOLD_W'(2), 1'b0);
    drain(50, 1'b0);

    apply_stimulus(1'b1, 1'b1, '0, 1'b0);
    drain(50, 1'b0);

    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    apply_stimulus(1'b1, 1'b1, '0, 1'b1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    drain(50, 1'b1);

    // Backpressure: keep in_val high until six long-hold requests get in.
    acc0 = accepted;
    n = 0;
    while (accepted < acc0 + 6 && n < 300) begin
      apply_stimulus(1'b1, 1'($urandom_range(0, 1)), HOLD_W'(15), 1'b0);
      n++;
    end
    checks++;
    if (accepted != acc0 + 6) begin
      failures++;
      $display("[TB] FAIL full_accepts actual=%0d required=%0d", accepted - acc0, 6);
    end
    drain(300, 1'b0);

    // Reset while holding with two requests still queued.
    apply_stimulus(1'b1, 1'b1, HOLD_W'(10), 1'b0);
    apply_stimulus(1'b1, 1'b0, HOLD_W'(3), 1'b0);
    apply_stimulus(1'b1, 1'b1, HOLD_W'(3), 1'b0);
    repeat (5) apply_stimulus(1'b0, 1'b0, '0, 1'b0);
    do_reset(2);
    repeat (20) apply_stimulus(1'b0, 1'b0, '0, 1'($urandom_range(0, 1)));

    for (int i = 0; i < 200; i++)
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     HOLD_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    drain(500, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
